itr_ctrl: RTL
=============

Name: itr_ctrl

Overview:
- Interrupt controller for the fixed-point processor core; it drives the core's single `itr` input.
- Collects NSRC external event lines and latches their rising edges as pending bits, then arbitrates them by fixed priority.
- Sequences one interrupt at a time: one-cycle `itr` pulse, then waits for end-of-interrupt (EOI) from the ISR.
- The core configures and reads it through its IO port: out_en/addr_out/data_out for writes, addr_in/io_in for reads.

Parameters:
- NUBITS, 32, data word width of the cfg/rd bus.
- NSRC, 8, number of interrupt sources (1..NUBITS-8).
- TOUT, 1024, service watchdog in clock cycles (>=2).
- GAP, 2, idle cycles enforced after EOI before the next `itr` (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- src  in  NSRC  interrupt request lines; rising-edge sensitive.
- cfg_wr  in  1  register write strobe from the core IO write.
- cfg_addr  in  2  register select, shared by read and write.
- cfg_data  in  NUBITS  write data.
- rd_data  out  NUBITS  combinational read of the register at cfg_addr.
- eoi  in  1  end-of-interrupt pulse from the ISR.
- itr  out  1  interrupt pulse to the core.
- busy  out  1  high from FIRE through SERV.

Behaviour:
- Reset (rst=0) clears everything: itr=0, busy=0, MASK=0, PEND=0, ID=0, OVF=0, LOST=0, src history=0, state=IDLE, counters=0. Reset mid-service aborts the service with no EOI required.
- Edge detection: src_q <= src each cycle. rise = src & ~src_q. PEND[i] is set in the cycle after the rising edge is sampled.
- LOST counter (8 bits) increments when rise[i] hits an already-set PEND[i]. It counts once per cycle regardless of how many bits collide, and saturates at 255.
- Register map:
  - 0 MASK: read/write, bits [NSRC-1:0]; upper bits read 0.
  - 1 PEND: read; write-1-to-clear.
  - 2 STAT: read-only {OVF at bit NSRC+1? no — OVF at bit 9, busy at bit 8, ID at bits [7:0]}, zero-extended.
  - 3 LOST: read; any write clears it to 0.
- Simultaneous events:
  - Set and W1C on the same PEND bit in the same cycle: set wins.
  - LOST increment and clear in the same cycle: clear wins.
- State machine:
  - IDLE: if |(PEND & MASK), latch ID = lowest set index, clear PEND[ID], go to FIRE.
  - FIRE: itr=1 for exactly this one cycle; load wdog=TOUT-1; go to SERV.
  - SERV: wdog decrements each cycle.
    - eoi=1: go to HOLD, load gap=GAP-1.
    - wdog==0 without eoi: set OVF, go to HOLD.
  - HOLD: gap decrements; at 0 go to IDLE.
- Latency: a rising edge on an enabled, idle source at cycle n gives itr=1 at n+3 (n+1 PEND, n+2 FIRE; the itr output is registered).
- Masking: a masked source still sets PEND and is served once unmasked. Masking has no effect on an interrupt already in FIRE or SERV.
- eoi outside SERV is ignored. eoi coinciding with wdog==0 counts as eoi; OVF stays unchanged.
- OVF is sticky until reset or until a write to STAT (any data) clears it.
- busy = (state==FIRE || state==SERV), registered.

Optional Feature:
- Macro ITR_SYNC_EN.
- Defined: src passes through a two-flop synchronizer before edge detection, adding 2 cycles of latency (n+5).
- Undefined: src must be synchronous to clk; edge detection is direct.

Test Plan:
- Reset then idle: rst low for 3 cycles, src=0 -> itr=0, rd_data=0 at every cfg_addr; MASK read = 0.
- Basic service: MASK=0x01, src[0] 0->1 at cycle 10 -> itr=1 only in cycle 13, busy=1 in cycles 13-14+, STAT.ID=0, PEND=0. eoi at cycle 20 -> busy=0 at 21; no further itr.
- Priority and queueing: MASK=0xFF, src[5] and src[2] rise in the same cycle -> first itr has ID=2 and PEND=0x20. After eoi plus GAP=2 cycles, a second itr with ID=5.
- Mask and lost: MASK=0, pulse src[3] three times -> PEND=0x08, LOST=2, no itr. Write MASK=0x08 -> itr with ID=3. Write to addr 3 -> LOST=0.
- Watchdog: TOUT=16, fire with no eoi -> state returns to IDLE after 16 SERV cycles plus GAP, STAT bit9 (OVF)=1. Write to STAT -> OVF=0.
- Collisions: W1C to PEND[1] in the same cycle src[1] rises -> PEND[1]=1. Assert rst during SERV -> itr=0, busy=0 immediately; no service resumes after release.

Source files
------------

// File: rtl/itr_ctrl.sv
// itr_ctrl: latches rising edges of NSRC event lines and serves them one at a time to the core's itr input.
// Build option ITR_SYNC_EN: adds a two-flop synchronizer in front of the edge detector.
module itr_ctrl #(
    parameter int NUBITS = 32,
    parameter int NSRC   = 8,
    parameter int TOUT   = 1024,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [NUBITS-1:0] cfg_data,
    output logic [NUBITS-1:0] rd_data,
    input  logic              eoi,
    output logic              itr,
    output logic              busy
);
    localparam int WW = $clog2(TOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE, FIRE, SERV, HOLD} state_t;

    state_t          r_state;
    logic [NSRC-1:0] w_src;
    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_pend;
    logic [7:0]      r_lost;
    logic [7:0]      r_id;
    logic            r_ovf;
    logic            r_itr;
    logic            r_busy;
    logic [WW-1:0]   r_wdog;
    logic [GW-1:0]   r_gap;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_req;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_take;
    logic [7:0]      w_sel;
    logic            w_hit;
    logic            w_coll;
    logic            w_unused;

`ifdef ITR_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src;
`endif

    assign w_rise   = w_src & ~r_src_q;
    assign w_coll   = |(w_rise & r_pend);
    assign w_req    = r_pend & r_mask;
    assign w_hit    = |w_req;
    assign w_clr    = (cfg_wr && cfg_addr == 2'd1) ? cfg_data[NSRC-1:0] : '0;
    assign w_take   = (w_hit && r_state == IDLE) ? (NSRC'(1) << w_sel) : '0;
    assign w_unused = ^cfg_data[NUBITS-1:NSRC];

    // Lowest index wins: scanning downward leaves the smallest set index in w_sel.
    always_comb begin
        w_sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req[i]) w_sel = 8'(i);
        end
    end

    always_comb begin
        rd_data = '0;
        case (cfg_addr)
            2'd0:    rd_data[NSRC-1:0] = r_mask;
            2'd1:    rd_data[NSRC-1:0] = r_pend;
            2'd2: begin
                rd_data[7:0] = r_id;
                rd_data[8]   = r_busy;
                rd_data[9]   = r_ovf;
            end
            default: rd_data[7:0] = r_lost;
        endcase
    end

    // A new rising edge is OR-ed in after the clears, so it survives a same-cycle W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_q <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
            r_lost  <= '0;
        end else begin
            r_src_q <= w_src;
            r_pend  <= (r_pend & ~w_clr & ~w_take) | w_rise;
            if (cfg_wr && cfg_addr == 2'd0) r_mask <= cfg_data[NSRC-1:0];
            if (cfg_wr && cfg_addr == 2'd3) r_lost <= '0;
            else if (w_coll && r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
        end
    end

    // busy follows the FIRE/SERV states exactly; itr trails FIRE by one register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_ovf   <= 1'b0;
            r_itr   <= 1'b0;
            r_busy  <= 1'b0;
            r_wdog  <= '0;
            r_gap   <= '0;
        end else begin
            r_itr <= 1'b0;
            if (cfg_wr && cfg_addr == 2'd2) r_ovf <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_id    <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= FIRE;
                    end
                end
                FIRE: begin
                    r_itr   <= 1'b1;
                    r_wdog  <= WW'(TOUT - 1);
                    r_state <= SERV;
                end
                SERV: begin
                    if (eoi || r_wdog == '0) begin
                        if (!eoi) r_ovf <= 1'b1;
                        r_gap   <= GW'(GAP - 1);
                        r_busy  <= 1'b0;
                        r_state <= HOLD;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_gap == '0) r_state <= IDLE;
                    else r_gap <= r_gap - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign itr  = r_itr;
    assign busy = r_busy;

endmodule
